// File: rtl/keypad_nav_ctrl.sv
// keypad_nav_ctrl
//   Button front-end for the on-screen keypad. Five raw push-buttons are
//   synchronised and debounced. Their rising edges become press events, and
//   the four direction buttons also auto-repeat while held. The events move a
//   cursor over a COLS x ROWS grid. A select press queues the key code under
//   the cursor in a small show-ahead FIFO.
//
// Ports
//   CLK        system clock, all state on the rising edge
//   RST        asynchronous active-low reset
//   BA/BB      raw up / down buttons (active high, asynchronous)
//   BI/BD      raw left / right buttons (active high, asynchronous)
//   BM         raw select button (active high, asynchronous)
//   COL, ROW   cursor position
//   KEY_VALID  FIFO non-empty
//   KEY_CODE   FIFO head, ROW*COLS+COL; keeps the last head value when empty
//   KEY_READY  consumer accepts the head
//   FILL       FIFO occupancy
//   OVERFLOW   sticky: a select was dropped because the FIFO was full
//
// Handshake: a key code transfers on every rising CLK edge where KEY_VALID
// and KEY_READY are both high. KEY_VALID does not depend on KEY_READY. A code
// pushed into an empty FIFO is not bypassed to the output. It becomes visible
// on the edge after the push.
module keypad_nav_ctrl #(
    parameter int COLS            = 4,
    parameter int ROWS            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int WRAP            = 1,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int KW = $clog2(COLS * ROWS),
    localparam int FW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BA,
    input  logic          BB,
    input  logic          BI,
    input  logic          BD,
    input  logic          BM,
    output logic [CW-1:0] COL,
    output logic [RW-1:0] ROW,
    output logic          KEY_VALID,
    output logic [KW-1:0] KEY_CODE,
    input  logic          KEY_READY,
    output logic [FW-1:0] FILL,
    output logic          OVERFLOW
);

    localparam int  DCW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int  RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int  RCW    = $clog2(RMAX + 1);
    localparam int  AW     = $clog2(FIFO_DEPTH);
    localparam bit  REP_EN = (REPEAT_DELAY != 0);

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DLY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST = RCW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0]  COL_MAX  = CW'(COLS - 1);
    localparam logic [RW-1:0]  ROW_MAX  = RW'(ROWS - 1);

    // Button index: 0 up, 1 down, 2 left, 3 right, 4 select
    logic [4:0]     raw;
    logic [4:0]     sync1;
    logic [4:0]     sync2;
    logic [4:0]     deb;
    logic [4:0]     deb_d;
    logic [4:0]     press;
    logic [DCW-1:0] dcnt [5];

    assign raw = {BM, BD, BI, BB, BA};

    // Synchroniser, debouncer and press-edge detector
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // press is registered from deb/deb_d, so it follows the debounced
            // edge by one cycle
            press <= deb & ~deb_d;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DEB_LAST) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // Auto-repeat for the direction buttons. The counter starts on the edge
    // that raises press. rfirst selects the initial delay over the steady
    // repeat rate.
    logic [3:0]     rpt;
    logic [3:0]     ractive;
    logic [3:0]     rfirst;
    logic [RCW-1:0] rcnt [4];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rpt     <= '0;
            ractive <= '0;
            rfirst  <= '0;
            for (int i = 0; i < 4; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!REP_EN || !deb[i]) begin
                    rpt[i]     <= 1'b0;
                    ractive[i] <= 1'b0;
                    rfirst[i]  <= 1'b0;
                    rcnt[i]    <= '0;
                end else if (!deb_d[i]) begin
                    rpt[i]     <= 1'b0;
                    ractive[i] <= 1'b1;
                    rfirst[i]  <= 1'b1;
                    rcnt[i]    <= '0;
                end else if (ractive[i]) begin
                    if (rcnt[i] == (rfirst[i] ? DLY_LAST : RATE_LAST)) begin
                        rpt[i]    <= 1'b1;
                        rfirst[i] <= 1'b0;
                        rcnt[i]   <= '0;
                    end else begin
                        rpt[i]  <= 1'b0;
                        rcnt[i] <= rcnt[i] + 1'b1;
                    end
                end else begin
                    rpt[i] <= 1'b0;
                end
            end
        end
    end

    // Cursor movement. Opposing events on one axis cancel each other.
    logic [3:0] ev;
    logic       mv_up;
    logic       mv_dn;
    logic       mv_lf;
    logic       mv_rt;

    assign ev    = press[3:0] | rpt;
    assign mv_up = ev[0] & ~ev[1];
    assign mv_dn = ev[1] & ~ev[0];
    assign mv_lf = ev[2] & ~ev[3];
    assign mv_rt = ev[3] & ~ev[2];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ROW <= '0;
            COL <= '0;
        end else begin
            if (mv_up) begin
                if (ROW == '0) ROW <= (WRAP != 0) ? ROW_MAX : ROW;
                else           ROW <= ROW - 1'b1;
            end else if (mv_dn) begin
                if (ROW == ROW_MAX) ROW <= (WRAP != 0) ? '0 : ROW;
                else                ROW <= ROW + 1'b1;
            end
            if (mv_lf) begin
                if (COL == '0) COL <= (WRAP != 0) ? COL_MAX : COL;
                else           COL <= COL - 1'b1;
            end else if (mv_rt) begin
                if (COL == COL_MAX) COL <= (WRAP != 0) ? '0 : COL;
                else                COL <= COL + 1'b1;
            end
        end
    end

    // Key-code FIFO. The code uses the cursor value before any move that
    // happens on the same edge.
    logic [KW-1:0] code;
    logic [KW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_n;
    logic [FW-1:0] count;
    logic [FW-1:0] count_n;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign code      = KW'(ROW) * KW'(COLS) + KW'(COL);
    assign full      = (count == FW'(FIFO_DEPTH));
    assign KEY_VALID = (count != '0);
    assign FILL      = count;
    assign do_pop    = KEY_VALID & KEY_READY;
    assign do_push   = press[4] & (~full | do_pop);

    always_comb begin
        rptr_n  = do_pop ? rptr + 1'b1 : rptr;
        count_n = count;
        if (do_push && !do_pop)      count_n = count + 1'b1;
        else if (!do_push && do_pop) count_n = count - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= code;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            KEY_CODE <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            rptr  <= rptr_n;
            count <= count_n;
            if (press[4] && full && !do_pop) OVERFLOW <= 1'b1;
            // The head register only changes while the FIFO holds something.
            // When the new head slot is the one being written, the data comes
            // from code rather than from mem.
            if (count_n != '0) begin
                if (do_push && (wptr == rptr_n)) KEY_CODE <= code;
                else                             KEY_CODE <= mem[rptr_n];
            end
        end
    end

endmodule

// File: tb/tb_keypad_nav_ctrl.sv
// tb_keypad_nav_ctrl
//   Directed bench for keypad_nav_ctrl with default parameters (wrapping
//   instance dut) plus a saturating instance dut_sat (WRAP=0).
//   Expected key codes go into exp_q when a select is issued. A monitor pops
//   and compares them at every accepted handshake.
module tb_keypad_nav_ctrl;

    localparam int KW = 4;

    localparam logic [4:0] M_UP  = 5'b00001;
    localparam logic [4:0] M_DN  = 5'b00010;
    localparam logic [4:0] M_LF  = 5'b00100;
    localparam logic [4:0] M_RT  = 5'b01000;
    localparam logic [4:0] M_SEL = 5'b10000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]    btn = '0;
    logic          key_ready = 1'b0;
    logic [1:0]    col;
    logic [1:0]    row;
    logic          key_valid;
    logic [KW-1:0] key_code;
    logic [2:0]    fill;
    logic          overflow;

    logic [4:0]    sbtn = '0;
    logic          s_ready = 1'b0;
    logic [1:0]    s_col;
    logic [1:0]    s_row;
    logic          s_valid;
    logic [KW-1:0] s_code;
    logic [2:0]    s_fill;
    logic          s_ovf;

    keypad_nav_ctrl dut (
        .CLK(clk), .RST(rst_n),
        .BA(btn[0]), .BB(btn[1]), .BI(btn[2]), .BD(btn[3]), .BM(btn[4]),
        .COL(col), .ROW(row), .KEY_VALID(key_valid), .KEY_CODE(key_code),
        .KEY_READY(key_ready), .FILL(fill), .OVERFLOW(overflow)
    );

    keypad_nav_ctrl #(.WRAP(0)) dut_sat (
        .CLK(clk), .RST(rst_n),
        .BA(sbtn[0]), .BB(sbtn[1]), .BI(sbtn[2]), .BD(sbtn[3]), .BM(sbtn[4]),
        .COL(s_col), .ROW(s_row), .KEY_VALID(s_valid), .KEY_CODE(s_code),
        .KEY_READY(s_ready), .FILL(s_fill), .OVERFLOW(s_ovf)
    );

    // scoreboard
    logic [KW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [4:0] mask, input bit to_sat, input int hold);
        if (to_sat) sbtn = mask;
        else        btn  = mask;
        tick(hold);
        if (to_sat) sbtn = '0;
        else        btn  = '0;
        tick(14);
    endtask

    task automatic select_code(input logic [KW-1:0] exp_code);
        exp_q.push_back(exp_code);
        pulse(M_SEL, 1'b0, 8);
    endtask

    task automatic drain(input int n);
        key_ready = 1'b1;
        tick(n);
        key_ready = 1'b0;
        tick(1);
    endtask

    // monitor: looks just after the negedge, when inputs are settled for the
    // coming rising edge
    always begin
        @(negedge clk);
        #1;
        if (rst_n && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL key_pop_unexpected actual=%0d expected=none", key_code);
            end else begin
                check("key_pop_code", int'(key_code), int'(exp_q.pop_front()));
            end
        end
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset
        tick(3);
        check("rst_col", col, 0);
        check("rst_row", row, 0);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_fill", fill, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick(10);
        check("idle_col", col, 0);
        check("idle_row", row, 0);
        check("idle_fill", fill, 0);

        // latency: first sampling edge n, COL changes at edge n+7
        btn = M_RT;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 6) check("lat_col_before", col, 0);
            if (k == 7) check("lat_col_after", col, 1);
        end
        btn = '0;
        tick(14);
        check("lat_col_final", col, 1);

        // glitch shorter than the debounce window
        pulse(M_RT, 1'b0, 3);
        check("glitch_col", col, 1);

        pulse(M_LF, 1'b0, 8);
        check("left_col", col, 0);

        // wrap at column edge
        pulse(M_RT, 1'b0, 8);
        check("wrap_col1", col, 1);
        pulse(M_RT, 1'b0, 8);
        check("wrap_col2", col, 2);
        pulse(M_RT, 1'b0, 8);
        check("wrap_col3", col, 3);
        pulse(M_RT, 1'b0, 8);
        check("wrap_col0", col, 0);
        pulse(M_UP, 1'b0, 8);
        check("wrap_row3", row, 3);
        pulse(M_DN, 1'b0, 8);
        check("wrap_row0", row, 0);

        // saturating instance
        pulse(M_RT, 1'b1, 8);
        check("sat_col1", s_col, 1);
        pulse(M_RT, 1'b1, 8);
        check("sat_col2", s_col, 2);
        pulse(M_RT, 1'b1, 8);
        check("sat_col3", s_col, 3);
        pulse(M_RT, 1'b1, 8);
        check("sat_col_hold", s_col, 3);
        pulse(M_UP, 1'b1, 8);
        check("sat_row_hold", s_row, 0);
        check("sat_fill", s_fill, 0);

        // auto-repeat: moves land at edges n+7, n+23, n+31, n+39
        btn = M_DN;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("rpt_row", row, ((k >= 7 ? 1 : 0) + (k >= 23 ? 1 : 0) +
                                   (k >= 31 ? 1 : 0) + (k >= 39 ? 1 : 0)) % 4);
            if (k == 39) btn = '0;
        end
        tick(10);
        check("rpt_row_final", row, 0);
        check("rpt_col_final", col, 0);

        // held select pushes once
        exp_q.push_back(4'd0);
        pulse(M_SEL, 1'b0, 40);
        check("hold_sel_fill", fill, 1);
        drain(1);
        check("hold_sel_fill_after", fill, 0);

        // select at (3,1)
        pulse(M_LF, 1'b0, 8);
        pulse(M_DN, 1'b0, 8);
        check("sel_col", col, 3);
        check("sel_row", row, 1);
        select_code(4'd7);
        check("sel_valid", key_valid, 1);
        check("sel_code", key_code, 7);
        check("sel_fill", fill, 1);
        drain(1);
        check("sel_fill_after", fill, 0);
        check("sel_valid_after", key_valid, 0);

        // overflow: five selects, fifth is dropped
        select_code(4'd7);
        pulse(M_RT, 1'b0, 8);
        select_code(4'd4);
        pulse(M_RT, 1'b0, 8);
        select_code(4'd5);
        pulse(M_RT, 1'b0, 8);
        select_code(4'd6);
        check("ovf_fill4", fill, 4);
        check("ovf_before", overflow, 0);
        pulse(M_RT, 1'b0, 8);
        pulse(M_SEL, 1'b0, 8);
        check("ovf_fill_full", fill, 4);
        check("ovf_set", overflow, 1);
        check("ovf_head", key_code, 7);
        drain(6);
        check("ovf_drained_fill", fill, 0);
        check("ovf_drained_valid", key_valid, 0);
        check("ovf_last_head", key_code, 6);
        check("ovf_sticky", overflow, 1);

        // select and right in the same cycle at (0,0)
        pulse(M_RT, 1'b0, 8);
        pulse(M_UP, 1'b0, 8);
        check("sim_col0", col, 0);
        check("sim_row0", row, 0);
        exp_q.push_back(4'd0);
        pulse(M_SEL | M_RT, 1'b0, 8);
        check("sim_fill", fill, 1);
        check("sim_code", key_code, 0);
        check("sim_col_after", col, 1);
        drain(2);

        // opposing buttons cancel
        pulse(M_UP | M_DN, 1'b0, 8);
        check("cancel_row", row, 0);
        pulse(M_LF | M_RT, 1'b0, 8);
        check("cancel_col", col, 1);

        check("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
